// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES round controller.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_IDLE   = 2'd0,
    OP_KEYEXP = 2'd1,
    OP_ENC    = 2'd2,
    OP_DEC    = 2'd3
  } op_e;

  localparam logic [1:0] KL_128  = 2'b00;
  localparam logic [1:0] KL_192  = 2'b01;
  localparam logic [1:0] KL_256  = 2'b10;
  localparam logic [1:0] KL_RSVD = 2'b11;

  localparam logic [1:0] KA_INIT = 2'b00;
  localparam logic [1:0] KA_RND  = 2'b01;
  localparam logic [1:0] KA_LAST = 2'b10;
  localparam logic [1:0] KA_INV  = 2'b11;

  // Final round index for a key length; reserved maps to the AES-128 count.
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_192:  nr_of = 4'd12;
      KL_256:  nr_of = 4'd14;
      default: nr_of = 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_seq.sv
// Operation register, shared step counter, NR latch, start arbitration,
// key-valid interlock and done generation.
module aes_round_seq
  import aes_ctrl_pkg::*;
#(
  parameter int NR_MAX = 14,
  parameter int KRF_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        keylen_i,
  input  logic              keyexp_i,
  input  logic              staenc_i,
  input  logic              stadec_i,
  input  logic              abort_i,
  output op_e               op_o,
  output logic [KRF_AW-1:0] s_o,
  output logic [KRF_AW-1:0] nr_o,
  output logic              key_valid_o,
  output logic              done_o,
  output logic              start_err_o,
  output logic              busy_o
);

  op_e               op_q, op_d;
  logic [KRF_AW-1:0] s_q, s_d;
  logic [KRF_AW-1:0] nr_q, nr_d;
  logic              kv_q, kv_d;
  logic [KRF_AW-1:0] nr_kl;
  logic              any_start;
  logic              last;

  // Requested round count, clamped so the key file is never overrun.
  assign nr_kl     = (KRF_AW'(nr_of(keylen_i)) > KRF_AW'(NR_MAX)) ?
                     KRF_AW'(NR_MAX) : KRF_AW'(nr_of(keylen_i));
  assign any_start = keyexp_i | staenc_i | stadec_i;
  assign last      = (s_q == nr_q);

  // State registers; reset restores the AES-128 round count.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= OP_IDLE;
      s_q  <= '0;
      nr_q <= KRF_AW'(10);
      kv_q <= 1'b0;
    end else begin
      op_q <= op_d;
      s_q  <= s_d;
      nr_q <= nr_d;
      kv_q <= kv_d;
    end
  end

  // Arbitration in IDLE, counter advance otherwise; abort beats everything.
  always_comb begin
    op_d        = op_q;
    s_d         = s_q;
    nr_d        = nr_q;
    kv_d        = kv_q;
    start_err_o = 1'b0;
    done_o      = 1'b0;
    case (op_q)
      OP_IDLE: begin
        s_d = '0;
        if (any_start) begin
          if (abort_i) begin
            start_err_o = 1'b1;
          end else if (keyexp_i) begin
            if (keylen_i == KL_RSVD) begin
              start_err_o = 1'b1;
            end else begin
              op_d        = OP_KEYEXP;
              nr_d        = nr_kl;
              kv_d        = 1'b0;
              start_err_o = staenc_i | stadec_i;
            end
          end else if (stadec_i) begin
            if (kv_q) begin
              op_d        = OP_DEC;
              start_err_o = staenc_i;
            end else begin
              start_err_o = 1'b1;
            end
          end else begin
            if (kv_q) op_d = OP_ENC;
            else      start_err_o = 1'b1;
          end
        end
      end
      OP_KEYEXP, OP_ENC, OP_DEC: begin
        start_err_o = any_start;
        if (abort_i) begin
          op_d = OP_IDLE;
          s_d  = '0;
        end else if (last) begin
          done_o = 1'b1;
          op_d   = OP_IDLE;
          s_d    = '0;
          if (op_q == OP_KEYEXP) kv_d = 1'b1;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      default: begin
        op_d = OP_IDLE;
        s_d  = '0;
      end
    endcase
  end

  assign op_o        = op_q;
  assign s_o         = s_q;
  assign nr_o        = nr_q;
  assign key_valid_o = kv_q;
  assign busy_o      = (op_q != OP_IDLE);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128/192/256 control unit: per-operation datapath decode around the
// shared round sequencer, plus the host load decode.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR_MAX = 14,
  parameter int KRF_AW = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [1:0]        keylen,
  input  logic              keyexp,
  input  logic              staenc,
  input  logic              stadec,
  input  logic              abort,
  output logic              keyexprdy,
  output logic              encdecrdy,
  output logic              key_valid,
  output logic              done,
  output logic              start_err,
  output logic              keysel,
  output logic              rndkren,
  output logic              wrrndkrf,
  output logic              rconen,
  output logic [KRF_AW-1:0] krfaddr,
  output logic              wrsben,
  output logic [ADDR_W-2:0] wrsbaddr,
  output logic              wrpckreg,
  output logic [1:0]        keyadsel,
  output logic              mixsel,
  output logic              reginsel,
  output logic              wrregen
);

  localparam logic [ADDR_W-1:0] PCK_ADDR = {1'b1, {(ADDR_W-1){1'b0}}};

  op_e               op;
  logic [KRF_AW-1:0] s, nr;
  logic              busy;
  logic              ld_block;

  aes_round_seq #(.NR_MAX(NR_MAX), .KRF_AW(KRF_AW)) u_seq (
    .clk         (clk),
    .rst         (rst),
    .keylen_i    (keylen),
    .keyexp_i    (keyexp),
    .staenc_i    (staenc),
    .stadec_i    (stadec),
    .abort_i     (abort),
    .op_o        (op),
    .s_o         (s),
    .nr_o        (nr),
    .key_valid_o (key_valid),
    .done_o      (done),
    .start_err_o (start_err),
    .busy_o      (busy)
  );

  assign keyexprdy = ~busy;
  assign encdecrdy = ~busy;

  // Host writes must not disturb the state registers mid-cipher.
  assign ld_block = (op == OP_ENC) | (op == OP_DEC);
  assign wrsben   = load & ~address[ADDR_W-1] & ~ld_block;
  assign wrsbaddr = address[ADDR_W-2:0];
  assign wrpckreg = load & (address == PCK_ADDR) & ~ld_block;

  // Datapath controls for the current operation and step.
  always_comb begin
    keysel   = 1'b0;
    rndkren  = 1'b0;
    wrrndkrf = 1'b0;
    rconen   = 1'b0;
    krfaddr  = '0;
    keyadsel = KA_INIT;
    mixsel   = 1'b0;
    reginsel = 1'b0;
    wrregen  = 1'b0;
    case (op)
      OP_KEYEXP: begin
        rndkren  = 1'b1;
        wrrndkrf = 1'b1;
        keysel   = (s != '0);
        rconen   = (s != '0);
        krfaddr  = s;
      end
      OP_ENC: begin
        wrregen = 1'b1;
        krfaddr = s;
        if (s == '0)      keyadsel = KA_INIT;
        else if (s == nr) keyadsel = KA_LAST;
        else              keyadsel = KA_RND;
      end
      OP_DEC: begin
        // Round keys are consumed in reverse order for decryption.
        wrregen  = 1'b1;
        krfaddr  = nr - s;
        keyadsel = (s == '0) ? KA_INIT : KA_INV;
        mixsel   = (s != '0) && (s != nr);
        reginsel = (s != '0) && (s != nr);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: scenario tasks plus a randomized run, all checked
// against a queue-of-expected-steps reference model.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, load, keyexp, staenc, stadec, abort;
  logic [4:0] address;
  logic [1:0] keylen;
  logic       keyexprdy, encdecrdy, key_valid, done, start_err;
  logic       keysel, rndkren, wrrndkrf, rconen, wrsben, wrpckreg;
  logic       mixsel, reginsel, wrregen;
  logic [3:0] krfaddr, wrsbaddr;
  logic [1:0] keyadsel;
  logic [23:0] obs, exp_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk(clk), .rst(rst), .load(load), .address(address), .keylen(keylen),
    .keyexp(keyexp), .staenc(staenc), .stadec(stadec), .abort(abort),
    .keyexprdy(keyexprdy), .encdecrdy(encdecrdy), .key_valid(key_valid),
    .done(done), .start_err(start_err), .keysel(keysel), .rndkren(rndkren),
    .wrrndkrf(wrrndkrf), .rconen(rconen), .krfaddr(krfaddr), .wrsben(wrsben),
    .wrsbaddr(wrsbaddr), .wrpckreg(wrpckreg), .keyadsel(keyadsel),
    .mixsel(mixsel), .reginsel(reginsel), .wrregen(wrregen)
  );

  assign obs = {keyexprdy, encdecrdy, key_valid, done, start_err, keysel, rndkren,
                wrrndkrf, rconen, krfaddr, wrsben, wrsbaddr, wrpckreg, keyadsel,
                mixsel, reginsel, wrregen};

  // Reference model: an accepted operation enqueues one entry per cycle it
  // will occupy; the queue front is the current cycle.
  typedef struct { int kind; int s; int nr; } step_t;  // kind 1=KX 2=ENC 3=DEC
  step_t q[$];
  bit    m_kv = 0;
  int    m_nr = 10;

  function automatic logic [23:0] model_exp();
    bit busy, kx, rej, ks, mx, blk, wsb, wpk, dn;
    int kind, s, nr, ka, kadr;
    busy = (q.size() != 0);
    kind = busy ? q[0].kind : 0;
    s    = busy ? q[0].s : 0;
    nr   = busy ? q[0].nr : 0;
    if (!(keyexp | staenc | stadec))  rej = 0;
    else if (busy || abort)          rej = 1;
    else if (keyexp)                 rej = (keylen == 2'b11) ? 1'b1 : (staenc | stadec);
    else if (stadec)                 rej = !m_kv ? 1'b1 : staenc;
    else                             rej = !m_kv;
    kx   = (kind == 1);
    ks   = kx && s != 0;
    kadr = (kind == 3) ? nr - s : s;
    if (kind == 2)      ka = (s == 0) ? 0 : (s == nr) ? 2 : 1;
    else if (kind == 3) ka = (s == 0) ? 0 : 3;
    else                ka = 0;
    mx   = (kind == 3) && s != 0 && s != nr;
    blk  = (kind >= 2);
    wsb  = load && address < 16 && !blk;
    wpk  = load && address == 16 && !blk;
    dn   = busy && s == nr && !abort;
    return {!busy, !busy, m_kv, dn, rej, ks, kx, kx, ks, 4'(kadr), wsb,
            4'(address % 16), wpk, 2'(ka), mx, mx, blk};
  endfunction

  task automatic push_op(input int kind);
    for (int s = 0; s <= m_nr; s++) q.push_back('{kind, s, m_nr});
  endtask

  // Apply inputs just after an edge, then compute expectation mid-cycle.
  task automatic drive(input bit r, k, e, d, ab, ld, input int addr, input int kl);
    rst = r; keyexp = k; staenc = e; stadec = d; abort = ab; load = ld;
    address = 5'(addr); keylen = 2'(kl);
    #4;
    exp_o = model_exp();
  endtask

  // Commit the edge to the model and move to just after it.
  task automatic advance();
    if (rst) begin
      q.delete(); m_kv = 0; m_nr = 10;
    end else if (q.size() != 0) begin
      if (abort) q.delete();
      else begin
        if (q[0].s == q[0].nr && q[0].kind == 1) m_kv = 1;
        void'(q.pop_front());
      end
    end else if (!abort) begin
      if (keyexp) begin
        if (keylen != 2'b11) begin
          m_kv = 0;
          m_nr = (keylen == 0) ? 10 : (keylen == 1) ? 12 : 14;
          push_op(1);
        end
      end else if (stadec) begin
        if (m_kv) push_op(3);
      end else if (staenc) begin
        if (m_kv) push_op(2);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (obs !== exp_o) begin
        n_err++; $display("FAIL %s cyc=%0d got=%h exp=%h", tag, i, obs, exp_o);
      end
      advance();
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== 24'hC00000) begin
      n_err++; $display("FAIL reset got=%h exp=%h", obs, 24'hC00000);
    end
    advance();
  endtask

  task automatic test_enc_nokey();
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== exp_o || start_err !== 1'b1 || encdecrdy !== 1'b1) begin
      n_err++; $display("FAIL enc_nokey got=%h exp=%h", obs, exp_o);
    end
    advance();
    run_idle(2, "enc_nokey_after");
  endtask

  task automatic test_keyexp128();
    int dn = 0, rk = 0;
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== exp_o) begin
      n_err++; $display("FAIL kx128_start got=%h exp=%h", obs, exp_o);
    end
    advance();
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      dn += done; rk += rndkren;
      n_vec++;
      if (obs !== exp_o) begin
        n_err++; $display("FAIL kx128 cyc=%0d got=%h exp=%h", i, obs, exp_o);
      end
      advance();
    end
    n_vec++;
    if (dn != 1 || rk != 11 || key_valid !== 1'b1) begin
      n_err++; $display("FAIL kx128_summary done=%0d rndkren=%0d kv=%b exp 1/11/1", dn, rk, key_valid);
    end
  endtask

  task automatic test_enc256();
    int rnd = 0;
    drive(0, 1, 0, 0, 0, 0, 0, 2);
    advance();
    run_idle(15, "kx256");
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    advance();
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rnd += (keyadsel == 2'b01);
      n_vec++;
      if (obs !== exp_o) begin
        n_err++; $display("FAIL enc256 cyc=%0d got=%h exp=%h", i, obs, exp_o);
      end
      advance();
    end
    n_vec++;
    if (rnd != 13) begin
      n_err++; $display("FAIL enc256_rnd got=%0d exp=13", rnd);
    end
  endtask

  task automatic test_dec192();
    int mx = 0;
    drive(0, 1, 0, 0, 0, 0, 0, 1);
    advance();
    run_idle(13, "kx192");
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    advance();
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      mx += (mixsel & reginsel);
      n_vec++;
      if (obs !== exp_o) begin
        n_err++; $display("FAIL dec192 cyc=%0d got=%h exp=%h", i, obs, exp_o);
      end
      advance();
    end
    n_vec++;
    if (mx != 11) begin
      n_err++; $display("FAIL dec192_mix got=%0d exp=11", mx);
    end
  endtask

  task automatic test_arbitration();
    drive(0, 1, 1, 1, 0, 0, 0, 0);
    n_vec++;
    if (obs !== exp_o || start_err !== 1'b1) begin
      n_err++; $display("FAIL multi_start got=%h exp=%h", obs, exp_o);
    end
    advance();
    run_idle(11, "multi_kx");
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    advance();
    run_idle(3, "enc_pre");
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== exp_o || start_err !== 1'b1) begin
      n_err++; $display("FAIL busy_start got=%h exp=%h", obs, exp_o);
    end
    advance();
    run_idle(9, "enc_post");
  endtask

  task automatic test_abort_rst();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    advance();
    run_idle(4, "kx_pre_abort");
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    n_vec++;
    if (obs !== exp_o || done !== 1'b0) begin
      n_err++; $display("FAIL abort_cycle got=%h exp=%h", obs, exp_o);
    end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== exp_o || key_valid !== 1'b0 || keyexprdy !== 1'b1) begin
      n_err++; $display("FAIL abort_after got=%h exp=%h", obs, exp_o);
    end
    advance();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    advance();
    run_idle(11, "kx_pre_enc");
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    advance();
    run_idle(6, "enc_pre_rst");
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs !== 24'hC00000) begin
      n_err++; $display("FAIL rst_mid got=%h exp=%h", obs, 24'hC00000);
    end
    advance();
  endtask

  task automatic test_load();
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 0, 1, a, 0);
      n_vec++;
      if (obs !== exp_o || wrsben !== (a < 16) || wrpckreg !== (a == 16)) begin
        n_err++; $display("FAIL load_idle addr=%0d got=%h exp=%h", a, obs, exp_o);
      end
      advance();
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    advance();
    run_idle(11, "kx_pre_load");
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    advance();
    for (int i = 0; i < 11; i++) begin
      drive(0, 0, 0, 0, 0, 1, (i == 0) ? 16 : i, 0);
      n_vec++;
      if (obs !== exp_o || wrsben !== 1'b0 || wrpckreg !== 1'b0) begin
        n_err++; $display("FAIL load_enc cyc=%0d got=%h exp=%h", i, obs, exp_o);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(199) == 0, $urandom_range(24) == 0,
            $urandom_range(12) == 0, $urandom_range(12) == 0,
            $urandom_range(40) == 0, $urandom_range(2) == 0,
            $urandom_range(31), $urandom_range(3));
      n_vec++;
      if (obs !== exp_o) begin
        n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_o);
      end
      advance();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; load = 0; address = 0; keylen = 0;
    keyexp = 0; staenc = 0; stadec = 0; abort = 0;
    @(posedge clk); #1;
    test_reset();
    test_enc_nokey();
    test_keyexp128();
    test_enc256();
    test_dec192();
    test_arbitration();
    test_abort_rst();
    test_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Parametrised AES control unit that sequences round-key expansion, encryption and decryption for AES-128/192/256 from one shared round counter. It replaces the fixed 10-round, three-FSM AES controller. It also adds key-length selection, a key-valid interlock, start arbitration with error reporting, a done pulse and abort. It sits between the host load/command interface and the AES datapath: S-box/state load, key register file, round-constant unit and the key-add/mix muxes.

## Interface
- NR_MAX, 14, maximum round count; sets round-key register file depth to NR_MAX+1.
- KRF_AW, 4, key register file address width; must satisfy 2^KRF_AW > NR_MAX.
- ADDR_W, 5, host load address width; bit ADDR_W-1 selects the register area, lower bits select the state/S-box area.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  host write strobe.
- address  in  ADDR_W  host write address.
- keylen  in  2  00=AES-128 (NR=10), 01=AES-192 (NR=12), 10=AES-256 (NR=14), 11=reserved.
- keyexp, staenc, stadec  in  1 each  single-cycle start requests.
- abort  in  1  terminates the active operation.
- keyexprdy, encdecrdy  out  1 each  controller idle (both equal ~busy).
- key_valid  out  1  round keys present for the latched key length.
- done  out  1  one-cycle pulse in the final active cycle.
- start_err  out  1  one-cycle pulse when a start request is rejected.
- keysel, rndkren, wrrndkrf, rconen  out  1 each  key-expansion controls.
- krfaddr  out  KRF_AW  key register file address.
- wrsben  out  1  state/S-box write enable.
- wrsbaddr  out  ADDR_W-1  state/S-box write address.
- wrpckreg  out  1  plaintext/ciphertext register write.
- keyadsel  out  2  key-add source select.
- mixsel, reginsel, wrregen  out  1 each  datapath mux controls and state register enable.

## Operation
- Operation register values: IDLE, KEYEXP, ENC, DEC. Step counter s runs from 0 to NR. NR is latched from keylen when keyexp is accepted.
- Acceptance happens only in IDLE. Priority is keyexp > stadec > staenc. Any other asserted start in the same cycle is dropped and pulses start_err.
- The following requests are rejected with a start_err pulse and no state change:
  - any start while busy;
  - staenc or stadec while key_valid=0;
  - keyexp with keylen=11.
- KEYEXP, for s=0..NR:
  - rndkren = wrrndkrf = 1;
  - keysel = rconen = (s≠0);
  - krfaddr = s.
  - Completion sets key_valid.
  - key_valid clears on acceptance of a new keyexp and stays 0 until that expansion completes.
- ENC, for s=0..NR:
  - wrregen = 1;
  - krfaddr = s;
  - keyadsel = 00 at s=0, 01 for 1..NR-1, 10 at s=NR;
  - mixsel = reginsel = 0.
- DEC, for s=0..NR:
  - wrregen = 1;
  - krfaddr = NR−s;
  - keyadsel = 00 at s=0, 11 otherwise;
  - mixsel = reginsel = 1 for s in 1..NR-1, 0 at s=0 and s=NR.
- In IDLE, all datapath controls are 0 and krfaddr = 0.
- Load decode is combinational and works in any state:
  - wrsben = load & ~address[ADDR_W-1];
  - wrsbaddr = address[ADDR_W-2:0];
  - wrpckreg = load & (address == 2^(ADDR_W-1)).
  - A load while the operation is ENC or DEC is ignored (wrsben = wrpckreg = 0).
- abort: the unit is IDLE in the next cycle with no done pulse. Aborting KEYEXP leaves key_valid=0. Aborting ENC/DEC keeps key_valid.

## Timing
- Reset values: operation IDLE, s=0, key_valid=0, latched NR=10, ready outputs 1, every other output 0.
- A start sampled at edge t gives s=0 outputs during cycle t+1. An operation occupies exactly NR+1 cycles: 11, 13 or 15.
- done is asserted with s=NR. Ready outputs return to 1 in the following cycle. A new start is accepted at the edge that ends the done cycle only if it is sampled in the IDLE cycle; starts during the done cycle get start_err.
- abort is sampled on the clock edge and has priority over counter advance. An abort in the same cycle as a start in IDLE is a no-op and the start is rejected.
- rst mid-operation returns to reset values at the next edge, including key_valid=0.
- s never exceeds NR. An illegal operation encoding falls back to IDLE.

## Structure
- Package aes_ctrl_pkg holds:
  - the operation enum;
  - the keylen encodings;
  - the function nr_of(keylen);
  - the keyadsel constants KA_INIT=00, KA_RND=01, KA_LAST=10, KA_INV=11.
- Sub-module aes_round_seq holds the operation register, step counter, NR latch, arbitration, key_valid and done. The top level holds the per-operation output decode and the load decode.

## Test plan
- Reset, then keyexp with keylen=00 → rndkren=1 for 11 cycles, krfaddr 0..10, keysel 0 then 1, done on the 11th cycle, key_valid=1 afterwards.
- staenc before any key expansion → start_err pulse, encdecrdy stays 1. After an AES-256 keyexp, staenc → 15 cycles with keyadsel 00, then 01 ×13, then 10, and krfaddr 0..14.
- AES-192 stadec → krfaddr 12 down to 0, reginsel=mixsel=1 for exactly 11 cycles, keyadsel=11 from the second cycle on.
- keyexp, staenc and stadec asserted in the same cycle → keyexp runs, start_err pulses. staenc during an active ENC → start_err, no disturbance.
- abort at s=4 of a keyexp → IDLE next cycle, no done, key_valid=0. rst at s=6 of ENC → all outputs return to reset values.
- Load sweep of addresses 0..31 in IDLE → wrsben for 0..15 with wrsbaddr equal to the address, wrpckreg only at 16. The same load during ENC → both 0.
